ba_pkt_mux4: RTL and testbench
==============================

# ba_pkt_mux4

Packet-level 4:1 stream multiplexer placed directly downstream of the 4-way round-robin arbiter, whose token advances on `ack`. It presents source requests to the arbiter and captures the one-hot grant. It then locks onto the granted source for a whole packet (through `s_last`), forwards beats through a registered output slice, and returns one `arb_ack` pulse per completed packet so the arbiter rotates. A beat watchdog truncates runaway packets.

## Interface
Parameters:
- `DATA_W`, default 32: beat payload width.
- `MAX_BEATS`, default 16: maximum beats per packet before forced truncation. Must be at least 2.
- `CNT_W`, default `$clog2(MAX_BEATS+1)`: beat counter width.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `s_valid` input 4: per-source beat valid.
- `s_last` input 4: per-source last-beat flag.
- `s_data` input 4×`DATA_W`: per-source payload, unpacked array `[4]`.
- `s_ready` output 4: per-source ready. At most one bit is high.
- `arb_req` output 4: requests to the arbiter.
- `arb_grant` input 4: one-hot (or zero) grant from the arbiter. Combinational from `arb_req`.
- `arb_ack` output 1: one-cycle, registered packet-done pulse to the arbiter.
- `m_valid` output 1: output beat valid.
- `m_data` output `DATA_W`: output payload.
- `m_last` output 1: output last-beat flag.
- `m_src` output 2: index of the source of the current output beat.
- `m_ready` input 1: downstream ready.
- `err_trunc` output 1: one-cycle pulse when the watchdog truncates a packet.

## Operation
- The FSM has three states: IDLE, LOCK and ACK.
- `arb_req` = `s_valid` while in IDLE, and 4'b0000 otherwise.
- **IDLE**
  - If `arb_grant` is exactly one-hot and `(arb_grant & s_valid) != 0`, register `sel` = index of the grant, clear the beat counter, and go to LOCK.
  - A zero, multi-hot, or non-valid grant is ignored; the FSM stays in IDLE.
- **LOCK**
  - `s_ready[sel]` = `~m_valid | m_ready`. All other `s_ready` bits are 0.
  - A beat is accepted when `s_valid[sel] & s_ready[sel]`. On acceptance, load the output slice with the beat: `m_data`, `m_last`, `m_src`=`sel`, and `m_valid`=1. Then increment the beat counter.
  - If the accepted beat has `s_last[sel]`=1, go to ACK.
  - If the accepted beat is beat number `MAX_BEATS` (counter == `MAX_BEATS`-1 before the increment) and `s_last`=0:
    - force `m_last`=1 on that output beat;
    - pulse `err_trunc` on the next cycle;
    - go to ACK.
    - The source's remaining beats form a new packet.
- **ACK**
  - `arb_ack`=1 for exactly this cycle.
  - No source is ready and no lock is taken.
  - Next state is IDLE unconditionally.
- **Output slice**
  - `m_valid` clears when `m_ready` is high and no new beat is loaded.
  - `m_data`, `m_last` and `m_src` hold while `m_valid & ~m_ready`.
  - `m_valid` never drops without `m_ready`, independent of FSM state. A beat held in the slice may still be draining during ACK or IDLE.
- **Arbiter contract**
  - `arb_grant` is sampled only in IDLE.
  - The arbiter's grant changes after the edge on which `arb_ack` is high. The ACK state guarantees the stale grant is never sampled.

## Timing
- Reset values:
  - state = IDLE, `sel`=0, beat counter = 0;
  - `m_valid`=0, `m_data`=0, `m_last`=0, `m_src`=0;
  - `arb_ack`=0, `err_trunc`=0;
  - `s_ready`=0 and `arb_req`=0 (derived from IDLE with `s_valid` low).
- Latency and throughput:
  - Source valid in IDLE at cycle 0 → LOCK at cycle 1 → first beat accepted in cycle 1 → `m_valid` at cycle 2.
  - Streaming throughput is 1 beat/cycle with `m_ready`=1.
- Packet turnaround: last beat accepted at cycle t → ACK at t+1 → IDLE at t+2 → next LOCK at t+3.
  - The minimum gap between packets is therefore 2 idle source cycles.
- Backpressure: with `m_ready`=0 and `m_valid`=1, `s_ready` is 0. The slice holds its contents and the FSM stays in LOCK.
- `err_trunc` and `arb_ack` both assert in the ACK cycle of a truncated packet.
- A reset mid-packet aborts it: the slice is emptied and no `arb_ack` is issued.

## Structure
- Shared package `ba_pkg` holds:
  - `BA_NPORTS`=4;
  - `typedef logic [1:0] ba_src_t`;
  - the `ba_mux_state_e` enum {IDLE, LOCK, ACK}.
- One sub-module, `ba_oh2idx`: a combinational one-hot-to-index encoder with an `onehot_ok` flag. It is also reusable by other arbiter-adjacent blocks.

## Test plan
- **Reset:** assert `rst_n`=0 with all sources valid → all outputs at reset values, `arb_req`=0.
- **Single 3-beat packet:** source 2, `arb_grant`=4'b0100, `m_ready`=1 → `m_src`=2 for 3 consecutive beats, `m_last` on the 3rd, a single `arb_ack` pulse 1 cycle after the last accept.
- **Back-to-back contention:** all 4 sources have 2-beat packets; the arbiter model grants 0,1,2,3 → output order is src 0,1,2,3, with exactly 2 `s_ready`-low cycles between packets and 4 `arb_ack` pulses.
- **Backpressure:** `m_ready`=0 for 5 cycles mid-packet → `m_data` stable, `s_ready`=0, no beat lost or duplicated; the stream resumes in order.
- **Watchdog:** `MAX_BEATS`=16, source 1 sends 20 beats with `s_last` only on beat 20 → beat 16 is output with `m_last`=1, `err_trunc` pulses once, and beats 17–20 appear as a second 4-beat packet after a re-grant.
- **Bad grant and mid-packet reset:** `arb_grant`=4'b0110 in IDLE → no lock. Then reset during beat 2 of a packet → `m_valid`=0 and no `arb_ack`.

Source files
------------

// File: rtl/ba_pkg.sv
// rtl/ba_pkg.sv - shared types for the arbiter-adjacent packet blocks
package ba_pkg;
  localparam int BA_NPORTS = 4;

  typedef logic [1:0] ba_src_t;

  typedef enum logic [1:0] {
    IDLE,
    LOCK,
    ACK
  } ba_mux_state_e;
endpackage

// File: rtl/ba_oh2idx.sv
// rtl/ba_oh2idx.sv - one-hot to index encoder with a one-hot validity flag
module ba_oh2idx
  import ba_pkg::*;
(
  input  logic [BA_NPORTS-1:0] onehot,
  output ba_src_t              idx,
  output logic                 onehot_ok
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < BA_NPORTS; i++) begin
      if (onehot[i]) idx = ba_src_t'(i);
    end
    onehot_ok = $onehot(onehot);
  end

endmodule

// File: rtl/ba_pkt_mux4.sv
// rtl/ba_pkt_mux4.sv - packet-locked 4:1 stream mux behind a round-robin arbiter
module ba_pkt_mux4
  import ba_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BA_NPORTS-1:0] s_valid,
  input  logic [BA_NPORTS-1:0] s_last,
  input  logic [DATA_W-1:0]    s_data [BA_NPORTS],
  output logic [BA_NPORTS-1:0] s_ready,
  output logic [BA_NPORTS-1:0] arb_req,
  input  logic [BA_NPORTS-1:0] arb_grant,
  output logic                 arb_ack,
  output logic                 m_valid,
  output logic [DATA_W-1:0]    m_data,
  output logic                 m_last,
  output logic [1:0]           m_src,
  input  logic                 m_ready,
  output logic                 err_trunc
);

  ba_mux_state_e     state_q, state_d;
  ba_src_t           sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  ba_src_t           m_src_q, m_src_d;
  logic              arb_ack_q, arb_ack_d;
  logic              err_trunc_q, err_trunc_d;

  ba_src_t grant_idx;
  logic    grant_ok;
  logic    slice_ready;
  logic    accept;
  logic    trunc;

  ba_oh2idx u_grant_enc (
    .onehot    (arb_grant),
    .idx       (grant_idx),
    .onehot_ok (grant_ok)
  );

  always_comb begin
    slice_ready = ~m_valid_q | m_ready;
    accept      = (state_q == LOCK) && s_valid[sel_q] && slice_ready;
    trunc       = accept && !s_last[sel_q] && (cnt_q == CNT_W'(MAX_BEATS - 1));

    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    arb_ack_d   = 1'b0;
    err_trunc_d = 1'b0;
    s_ready     = '0;
    // Requests are masked while reset is held so the arbiter sees nothing.
    arb_req     = (state_q == IDLE && rst_n) ? s_valid : '0;

    unique case (state_q)
      IDLE: begin
        if (grant_ok && ((arb_grant & s_valid) != '0)) begin
          sel_d   = grant_idx;
          cnt_d   = '0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        s_ready[sel_q] = slice_ready;
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (s_last[sel_q] || trunc) begin
            state_d     = ACK;
            arb_ack_d   = 1'b1;
            err_trunc_d = trunc;
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_src_d   = m_src_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data[sel_q];
      m_last_d  = s_last[sel_q] | trunc;
      m_src_d   = sel_q;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      m_src_q     <= '0;
      arb_ack_q   <= 1'b0;
      err_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      m_src_q     <= m_src_d;
      arb_ack_q   <= arb_ack_d;
      err_trunc_q <= err_trunc_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign m_src     = m_src_q;
  assign arb_ack   = arb_ack_q;
  assign err_trunc = err_trunc_q;

endmodule

// File: tb/tb_ba_pkt_mux4.sv
// tb/tb_ba_pkt_mux4.sv - scoreboard bench for ba_pkt_mux4
module tb_ba_pkt_mux4;
  localparam int DATA_W    = 32;
  localparam int MAX_BEATS = 16;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        s_valid = '0;
  logic [3:0]        s_last = '0;
  logic [DATA_W-1:0] s_data [4];
  logic [3:0]        s_ready;
  logic [3:0]        arb_req;
  logic [3:0]        arb_grant;
  logic              arb_ack;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic [1:0]        m_src;
  logic              m_ready = 1'b1;
  logic              err_trunc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int trunc_cnt = 0;
  int beats_out = 0;
  bit log_en = 1'b0;
  int acc_cyc[$];

  beat_t src_q[4][$];
  exp_t  exp_q[$];
  logic [3:0] hs_n = '0;
  logic [3:0] hs_e;

  logic       force_en = 1'b0;
  logic [3:0] grant_force = '0;
  logic [3:0] rr_grant;
  logic [1:0] rr_idx;
  logic [1:0] rr_ptr, last_g;

  ba_pkt_mux4 #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .arb_req   (arb_req),
    .arb_grant (arb_grant),
    .arb_ack   (arb_ack),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_src     (m_src),
    .m_ready   (m_ready),
    .err_trunc (err_trunc)
  );

  always #5 clk = ~clk;

  // Round-robin arbiter model; token advances past the last grant on arb_ack.
  always_comb begin
    rr_grant = '0;
    rr_idx   = '0;
    for (int k = 3; k >= 0; k--) begin
      int j;
      j = (int'(rr_ptr) + k) % 4;
      if (arb_req[j]) begin
        rr_grant = 4'b0001 << j;
        rr_idx   = 2'(j);
      end
    end
    arb_grant = force_en ? grant_force : rr_grant;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      last_g <= '0;
    end else begin
      if (!force_en && rr_grant != '0) last_g <= rr_idx;
      if (arb_ack) rr_ptr <= last_g + 2'd1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_pkt(input int src, input int n, input logic [31:0] base);
    int    k;
    beat_t sb;
    exp_t  eb;
    k = 0;
    for (int b = 1; b <= n; b++) begin
      k++;
      sb.data = base + 32'(b);
      sb.last = (b == n);
      eb.src  = 2'(src);
      eb.data = sb.data;
      eb.last = (b == n) || (k == MAX_BEATS);
      if (eb.last) k = 0;
      src_q[src].push_back(sb);
      exp_q.push_back(eb);
    end
  endtask

  function automatic bit src_busy();
    for (int i = 0; i < 4; i++) if (src_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src_busy() || m_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 64'(n < budget), 1);
    repeat (4) @(negedge clk);
  endtask

  // Source driver: pop on the handshake seen at the edge, then present the next beat.
  always @(posedge clk) begin
    cyc  = cyc + 1;
    hs_e = hs_n;
    #1;
    for (int i = 0; i < 4; i++)
      if (hs_e[i] && rst_n && src_q[i].size() != 0) void'(src_q[i].pop_front());
    #1;
    for (int i = 0; i < 4; i++) begin
      s_valid[i] = (src_q[i].size() != 0);
      s_data[i]  = (src_q[i].size() != 0) ? src_q[i][0].data : '0;
      s_last[i]  = (src_q[i].size() != 0) ? src_q[i][0].last : 1'b0;
    end
  end

  // Monitor: sample away from the active edge and score every output beat.
  always @(negedge clk) begin
    exp_t e;
    hs_n = s_valid & s_ready;
    if (rst_n) begin
      if (arb_ack) ack_cnt++;
      if (err_trunc) begin
        trunc_cnt++;
        chk("trunc_with_ack", 64'(arb_ack), 1);
      end
      if (s_ready != '0) chk("s_ready_onehot", 64'($onehot(s_ready)), 1);
      if (log_en && hs_n != '0) acc_cyc.push_back(cyc);
      if (m_valid && m_ready) begin
        beats_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(m_data), 0);
          errors += (m_data == 0) ? 1 : 0;
        end else begin
          e = exp_q.pop_front();
          chk("m_src", 64'(m_src), 64'(e.src));
          chk("m_data", 64'(m_data), 64'(e.data));
          chk("m_last", 64'(m_last), 64'(e.last));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: stuck at t=%0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    int a0, t0, b0, n;
    logic [31:0] hold;

    // Reset with every source valid.
    for (int i = 0; i < 4; i++) send_pkt(i, 1, 32'h0100_0000 + 32'(i << 16));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 0);
    chk("rst_m_data", 64'(m_data), 0);
    chk("rst_m_last", 64'(m_last), 0);
    chk("rst_m_src", 64'(m_src), 0);
    chk("rst_arb_ack", 64'(arb_ack), 0);
    chk("rst_err_trunc", 64'(err_trunc), 0);
    chk("rst_s_ready", 64'(s_ready), 0);
    chk("rst_arb_req", 64'(arb_req), 0);
    rst_n = 1'b1;
    wait_idle(100);
    chk("rst_flow_acks", 64'(ack_cnt), 4);

    // Back-to-back contention, 2-beat packets on all sources.
    a0 = ack_cnt;
    acc_cyc.delete();
    log_en = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_pkt(i, 2, 32'h0200_0000 + 32'(i << 16));
    wait_idle(200);
    log_en = 1'b0;
    chk("bb_accepts", 64'(acc_cyc.size()), 8);
    if (acc_cyc.size() == 8) begin
      chk("bb_gap", 64'(acc_cyc[2] - acc_cyc[1]), 3);
      chk("bb_span", 64'(acc_cyc[7] - acc_cyc[0]), 13);
    end
    chk("bb_acks", 64'(ack_cnt - a0), 4);

    // Single 3-beat packet from source 2 with cycle-exact timing.
    a0 = ack_cnt;
    @(posedge clk); #1;
    send_pkt(2, 3, 32'h0300_0000);
    @(negedge clk);
    chk("sp_c0_arb_req", 64'(arb_req), 4'b0100);
    chk("sp_c0_m_valid", 64'(m_valid), 0);
    @(negedge clk);
    chk("sp_c1_s_ready", 64'(s_ready), 4'b0100);
    chk("sp_c1_m_valid", 64'(m_valid), 0);
    @(negedge clk);
    chk("sp_c2_m_valid", 64'(m_valid), 1);
    @(negedge clk);
    @(negedge clk);
    chk("sp_c4_arb_ack", 64'(arb_ack), 1);
    chk("sp_c4_m_last", 64'(m_last), 1);
    wait_idle(100);
    chk("sp_acks", 64'(ack_cnt - a0), 1);

    // Backpressure for 5 cycles mid-packet.
    a0 = ack_cnt;
    b0 = beats_out;
    @(posedge clk); #1;
    send_pkt(0, 6, 32'h0400_0000);
    n = 0;
    while (beats_out < b0 + 2 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("bp_started", 64'(beats_out >= b0 + 2), 1);
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    hold = m_data;
    chk("bp_m_valid", 64'(m_valid), 1);
    chk("bp_s_ready", 64'(s_ready), 0);
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold", 64'(m_data), 64'(hold));
      chk("bp_s_ready", 64'(s_ready), 0);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_idle(100);
    chk("bp_beats", 64'(beats_out - b0), 6);
    chk("bp_acks", 64'(ack_cnt - a0), 1);

    // Watchdog: 20-beat packet on source 1 splits into 16 + 4.
    a0 = ack_cnt;
    t0 = trunc_cnt;
    @(posedge clk); #1;
    send_pkt(1, 20, 32'h0500_0000);
    wait_idle(300);
    chk("wd_trunc", 64'(trunc_cnt - t0), 1);
    chk("wd_acks", 64'(ack_cnt - a0), 2);

    // Multi-hot grant is ignored, then a clean grant resumes.
    a0 = ack_cnt;
    @(posedge clk); #1;
    force_en    = 1'b1;
    grant_force = 4'b0110;
    send_pkt(2, 1, 32'h0600_0000);
    send_pkt(1, 1, 32'h0610_0000);
    repeat (5) @(negedge clk);
    chk("bg_arb_req", 64'(arb_req), 4'b0110);
    chk("bg_s_ready", 64'(s_ready), 0);
    chk("bg_m_valid", 64'(m_valid), 0);
    chk("bg_acks", 64'(ack_cnt - a0), 0);
    @(posedge clk); #1;
    force_en = 1'b0;
    wait_idle(100);
    chk("bg_after_acks", 64'(ack_cnt - a0), 2);

    // Reset while beat 2 of a 4-beat packet is being accepted.
    a0 = ack_cnt;
    b0 = beats_out;
    @(posedge clk); #1;
    send_pkt(3, 4, 32'h0700_0000);
    n = 0;
    while (beats_out < b0 + 1 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("mr_first_beat", 64'(beats_out - b0), 1);
    rst_n = 1'b0;
    src_q[3].delete();
    repeat (2) @(negedge clk);
    chk("mr_m_valid", 64'(m_valid), 0);
    chk("mr_s_ready", 64'(s_ready), 0);
    chk("mr_arb_ack", 64'(arb_ack), 0);
    chk("mr_pending", 64'(exp_q.size()), 3);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mr_no_ack", 64'(ack_cnt - a0), 0);
    chk("mr_idle_m_valid", 64'(m_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
